// File: rtl/fetch_stage_q_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_q_pkg
// Brief    : Shared widths, the IF/ID register layout and helpers for the fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_stage_q_pkg;

    localparam int c_PC_W     = 16;
    localparam int c_INSTR_W  = 16;
    localparam int c_PC_STEP  = 2;
    localparam int c_RESET_PC = 0;
    localparam int c_QDEPTH   = 2;
    localparam int IF_ID_W    = 1 + c_PC_W + c_INSTR_W;

    typedef struct packed {
        logic                 valid;
        logic [c_PC_W-1:0]    pcn;
        logic [c_INSTR_W-1:0] instr;
    } if_id_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to index depth entries (never less than one).
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : fetch_stage_q_pkg
`default_nettype wire

// File: rtl/fetch_stage_q_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Synchronous FIFO buffering fetched words; clear beats push.
// Revision : 1.0
// ============================================================================
module fetch_queue
    import fetch_stage_q_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [count_bits(DEPTH)-1:0]  count,
    output logic [WIDTH-1:0]              head
);

    localparam int c_CW = count_bits(DEPTH);
    localparam int c_PW = ptr_bits(DEPTH);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_PW-1:0] c_LAST    = c_PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    function automatic logic [c_PW-1:0] ptr_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    // A push into a full queue is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == c_FULL);
        w_do_pop  = pop && !w_empty;
        w_do_push = push && (!w_full || w_do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // Storage carries no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_stage_q.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_q
// Brief    : Queued instruction fetch stage with decode backpressure and redirect.
// Revision : 1.0
// ============================================================================
module fetch_stage_q
    import fetch_stage_q_pkg::*;
#(
    parameter int PC_W     = c_PC_W,
    parameter int INSTR_W  = c_INSTR_W,
    parameter int PC_STEP  = c_PC_STEP,
    parameter int RESET_PC = c_RESET_PC,
    parameter int QDEPTH   = c_QDEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_redirect,
    input  logic [PC_W-1:0]           i_redirect_pc,
    input  logic                      i_stall,
    output logic [PC_W-1:0]           o_pc_addr,
    output logic                      o_pc_rd,
    input  logic [INSTR_W-1:0]        i_pc_rddata,
    output logic [PC_W+INSTR_W:0]     IF_ID,
    output logic [PC_W-1:0]           PC
);

    localparam int c_EW  = PC_W + INSTR_W;
    localparam int c_CW  = count_bits(QDEPTH);
    localparam int c_OW  = c_CW + 1;
    localparam logic [PC_W-1:0] c_STEP   = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] c_RST_PC = PC_W'(RESET_PC);
    localparam logic [c_OW-1:0] c_QLIM   = c_OW'(QDEPTH);

    logic [PC_W-1:0]  r_pc;
    logic             r_pend;
    logic [PC_W-1:0]  r_pend_pc;
    logic [c_EW:0]    r_if_id;

    logic [c_CW-1:0]  w_count;
    logic [c_EW-1:0]  w_head;
    logic [c_EW-1:0]  w_entry;
    logic [c_OW-1:0]  w_occ;
    logic             w_deq;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    // w_occ is the occupancy at end of cycle, counting the word already in flight.
    always_comb begin
        w_deq   = (w_count != '0) && !i_stall;
        w_occ   = c_OW'(w_count) + c_OW'(r_pend) - c_OW'(w_deq);
        w_issue = !reset && !i_redirect && (w_occ < c_QLIM);
        w_push  = r_pend && !i_redirect;
        w_pop   = w_deq && !i_redirect;
        w_entry = {r_pend_pc + c_STEP, i_pc_rddata};
    end

    fetch_queue #(
        .WIDTH (c_EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .clear (i_redirect),
        .push  (w_push),
        .din   (w_entry),
        .pop   (w_pop),
        .count (w_count),
        .head  (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= c_RST_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= c_RST_PC;
        end else begin
            if (i_redirect) begin
                r_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + c_STEP;
            end
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_pc <= r_pc;
            end
        end
    end

    // Redirect squashes IF/ID even while decode is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_id <= '0;
        end else if (i_redirect) begin
            r_if_id <= '0;
        end else if (!i_stall) begin
            if (w_count != '0) begin
                r_if_id <= {1'b1, w_head};
            end else begin
                r_if_id[c_EW] <= 1'b0;
            end
        end
    end

    assign o_pc_addr = r_pc;
    assign o_pc_rd   = w_issue;
    assign PC        = r_pc;
    assign IF_ID     = r_if_id;

endmodule : fetch_stage_q
`default_nettype wire

// File: tb/tb_fetch_stage_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage_q
// Brief    : Scoreboard bench for fetch_stage_q against an in-order fetch stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage_q;
    import fetch_stage_q_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               redir = 1'b0;
    logic [15:0]        redir_pc = '0;
    logic               stall = 1'b0;
    logic [15:0]        pc_addr;
    logic               pc_rd;
    logic [15:0]        rddata = '0;
    logic [IF_ID_W-1:0] if_id;
    logic [15:0]        pc;

    fetch_stage_q #(
        .PC_W     (16),
        .INSTR_W  (16),
        .PC_STEP  (2),
        .RESET_PC (0),
        .QDEPTH   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_redirect    (redir),
        .i_redirect_pc (redir_pc),
        .i_stall       (stall),
        .o_pc_addr     (pc_addr),
        .o_pc_rd       (pc_rd),
        .i_pc_rddata   (rddata),
        .IF_ID         (if_id),
        .PC            (pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] next_push;
    if_id_t      mon_v;

    function automatic logic [15:0] imem_f(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A5A;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) rddata <= pc_rd ? imem_f(pc_addr) : 16'($urandom);

    function automatic if_id_t cur();
        return if_id_t'(if_id);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected program order: addresses the decoder should see, in sequence.
    function automatic void topup();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_push);
            next_push = next_push + 16'd2;
        end
    endfunction

    function automatic void reload(input logic [15:0] a);
        exp_q.delete();
        next_push = a;
        topup();
    endfunction

    // Monitor: every instruction decode accepts must be the next one in program order.
    always @(negedge clk) begin
        mon_v = cur();
        if (!reset && mon_v.valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_underflow: got pcn %h, expected nothing", mon_v.pcn);
            end else begin
                logic [15:0] a;
                a = exp_q.pop_front();
                chk("stream", {mon_v.pcn, mon_v.instr}, {a + 16'd2, imem_f(a)});
                pops++;
            end
        end
    end

    task automatic drive(input bit s, input bit r, input logic [15:0] t);
        stall    = s;
        redir    = r;
        redir_pc = t;
    endtask

    task automatic step();
        @(posedge clk);
        if (redir) reload(redir_pc);
        topup();
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!cur().valid && n < 12) begin
            step();
            n++;
        end
        if (!cur().valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got valid 0, expected valid 1", name);
        end
    endtask

    // Called in the first cycle after reset is released.
    task automatic restart_checks(input string tag);
        drive(0, 0, 16'h0);
        #1;
        chk({tag, "_addr0"}, pc_addr, 16'h0000);
        chk({tag, "_rd0"}, pc_rd, 1'b1);
        step();
        chk({tag, "_addr1"}, pc_addr, 16'h0002);
        chk({tag, "_v1"}, cur().valid, 1'b0);
        step();
        chk({tag, "_addr2"}, pc_addr, 16'h0004);
        chk({tag, "_v2"}, cur().valid, 1'b0);
        step();
        chk({tag, "_v3"}, cur().valid, 1'b1);
        chk({tag, "_pcn3"}, cur().pcn, 16'h0002);
        chk({tag, "_instr3"}, cur().instr, imem_f(16'h0000));
        step();
        chk({tag, "_pcn4"}, cur().pcn, 16'h0004);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        reload(16'h0);
        #2;
        chk("rst_rd", pc_rd, 1'b0);
        chk("rst_ifid", if_id, '0);
        chk("rst_pc", pc, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        restart_checks("t1");

        // Stall four cycles once the pipeline is streaming.
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 16'h0);
            #1;
            chk("stall_valid", cur().valid, 1'b1);
            chk("stall_hold", cur().pcn, exp_q[0] + 16'd2);
            if (k >= 1) chk("stall_no_rd", pc_rd, 1'b0);
            step();
        end
        drive(0, 0, 16'h0);
        repeat (4) step();

        // Redirect while a response is in flight.
        drive(0, 1, 16'h0100);
        #1;
        chk("redir_rd_off", pc_rd, 1'b0);
        step();
        drive(0, 0, 16'h0);
        #1;
        chk("redir_flush", cur().valid, 1'b0);
        chk("redir_addr", pc_addr, 16'h0100);
        chk("redir_rd", pc_rd, 1'b1);
        wait_valid("redir");
        chk("redir_pcn", cur().pcn, 16'h0102);
        chk("redir_instr", cur().instr, imem_f(16'h0100));
        repeat (2) step();

        // Redirect and stall together.
        drive(1, 1, 16'h0200);
        step();
        drive(1, 0, 16'h0);
        #1;
        chk("rs_flush", cur().valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rs_hold_invalid", cur().valid, 1'b0);
        end
        drive(0, 0, 16'h0);
        wait_valid("rs");
        chk("rs_pcn", cur().pcn, 16'h0202);
        repeat (2) step();

        // PC wrap at the top of the address space.
        drive(0, 1, 16'hFFFC);
        step();
        drive(0, 0, 16'h0);
        #1;
        chk("wrap_a0", pc_addr, 16'hFFFC);
        step();
        chk("wrap_a1", pc_addr, 16'hFFFE);
        step();
        chk("wrap_a2", pc_addr, 16'h0000);
        wait_valid("wrap");
        chk("wrap_p0", cur().pcn, 16'hFFFE);
        step();
        chk("wrap_p1", cur().pcn, 16'h0000);
        step();
        chk("wrap_p2", cur().pcn, 16'h0002);
        repeat (3) step();

        // Asynchronous reset between clock edges.
        drive(0, 0, 16'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_pc", pc, 16'h0000);
        chk("areset_ifid", if_id, '0);
        chk("areset_rd", pc_rd, 1'b0);
        reload(16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        restart_checks("t6");

        // Randomised stall/redirect traffic, checked by the monitor.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) < 3, ($urandom % 20) == 0,
                  {15'($urandom), 1'b0});
            step();
        end
        drive(0, 0, 16'h0);
        p0 = pops;
        repeat (10) step();
        chk("drain_flow", 32'((pops - p0) >= 6), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_stage_q
`default_nettype wire
